feistel_engine: RTL and testbench

- Parametrised Blowfish/bcrypt Feistel round engine; successor to the fixed 16-round encrypt-only core.
- Fetches P-array and S-box words from two single-cycle SRAM read ports (A, B).
- Configurable round count and memory map; selectable encrypt/decrypt per block; explicit ready/busy/done handshake.
- Sits under the bcrypt key-schedule/encrypt controller, which owns the SRAMs between operations.

---
 rtl/feistel_engine.sv | 215 +++++++++++++++++++++
 tb/tb_feistel_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feistel_engine.sv
// Blowfish/bcrypt Feistel round engine: three cycles per round over two single-cycle SRAM read ports.
// Defining FEISTEL_WRITEBACK_EN adds an optional write-back of the result pair after each block.
module feistel_engine #(
  parameter int ROUNDS = 16,
  parameter int ADDR_W = 12,
  parameter int S_BASE = 0,
  parameter int P_BASE = 4000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              decrypt,
  input  logic [31:0]       L,
  input  logic [31:0]       R,
`ifdef FEISTEL_WRITEBACK_EN
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wdata_a,
  output logic [31:0]       wdata_b,
`endif
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       resultL,
  output logic [31:0]       resultR,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [31:0]       data_a,
  input  logic [31:0]       data_b,
  output logic              cs_a_l,
  output logic              cs_b_l,
  output logic              we_a_l,
  output logic              we_b_l,
  output logic              oe_a_l,
  output logic              oe_b_l
);

  localparam int CW = $clog2(ROUNDS + 1);
  typedef logic [ADDR_W-1:0] addr_t;
  localparam addr_t S0_A = addr_t'(S_BASE);
  localparam addr_t S1_A = addr_t'(S_BASE + 256);
  localparam addr_t S2_A = addr_t'(S_BASE + 512);
  localparam addr_t S3_A = addr_t'(S_BASE + 768);
  localparam addr_t P_A  = addr_t'(P_BASE);

  typedef enum logic [2:0] {IDLE, S01, S23, MIX, FIN, WB, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   l_q, l_d, r_q, r_d, fr_q, fr_d;
  logic [31:0]   res_l_q, res_l_d, res_r_q, res_r_d;
  logic [CW-1:0] round_q, round_d;
  logic          dec_q, dec_d;
`ifdef FEISTEL_WRITEBACK_EN
  logic          wb_en_q, wb_en_d;
  addr_t         wb_addr_q, wb_addr_d;
`endif

  logic [31:0] lx;
  logic        last_round;
  addr_t       pidx_next;

  assign lx         = l_q ^ data_a;
  assign last_round = (round_q == CW'(ROUNDS - 1));
  assign pidx_next  = dec_q ? (addr_t'(ROUNDS) - addr_t'(round_q)) : (addr_t'(round_q) + addr_t'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      l_q       <= '0;
      r_q       <= '0;
      fr_q      <= '0;
      res_l_q   <= '0;
      res_r_q   <= '0;
      round_q   <= '0;
      dec_q     <= 1'b0;
`ifdef FEISTEL_WRITEBACK_EN
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      r_q       <= r_d;
      fr_q      <= fr_d;
      res_l_q   <= res_l_d;
      res_r_q   <= res_r_d;
      round_q   <= round_d;
      dec_q     <= dec_d;
`ifdef FEISTEL_WRITEBACK_EN
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    r_d       = r_q;
    fr_d      = fr_q;
    res_l_d   = res_l_q;
    res_r_d   = res_r_q;
    round_d   = round_q;
    dec_d     = dec_q;
`ifdef FEISTEL_WRITEBACK_EN
    wb_en_d   = wb_en_q;
    wb_addr_d = wb_addr_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d   = S01;
        l_d       = L;
        r_d       = R;
        dec_d     = decrypt;
        round_d   = '0;
`ifdef FEISTEL_WRITEBACK_EN
        wb_en_d   = wb_en;
        wb_addr_d = wb_addr;
`endif
      end
      S01: begin
        l_d     = lx;
        state_d = S23;
      end
      S23: begin
        fr_d    = data_a + data_b;
        state_d = MIX;
      end
      MIX: begin
        l_d     = r_q ^ ((fr_q ^ data_a) + data_b);
        r_d     = l_q;
        round_d = round_q + CW'(1);
        state_d = last_round ? FIN : S01;
      end
      FIN: begin
        // L/R are left swapped by the last MIX, so the final un-swap is folded in here
        res_l_d = r_q ^ data_a;
        res_r_d = l_q ^ data_b;
`ifdef FEISTEL_WRITEBACK_EN
        state_d = wb_en_q ? WB : DONE;
`else
        state_d = DONE;
`endif
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_a = '0;
    addr_b = '0;
    cs_a_l = 1'b1;
    cs_b_l = 1'b1;
    we_a_l = 1'b1;
    we_b_l = 1'b1;
    oe_a_l = 1'b0;
    oe_b_l = 1'b0;
`ifdef FEISTEL_WRITEBACK_EN
    wdata_a = '0;
    wdata_b = '0;
`endif
    case (state_q)
      IDLE: if (start) begin
        cs_a_l = 1'b0;
        addr_a = P_A + (decrypt ? addr_t'(ROUNDS + 1) : addr_t'(0));
      end
      S01: begin
        cs_a_l = 1'b0;
        cs_b_l = 1'b0;
        addr_a = S0_A + addr_t'(lx[31:24]);
        addr_b = S1_A + addr_t'(lx[23:16]);
      end
      S23: begin
        cs_a_l = 1'b0;
        cs_b_l = 1'b0;
        addr_a = S2_A + addr_t'(l_q[15:8]);
        addr_b = S3_A + addr_t'(l_q[7:0]);
      end
      MIX: begin
        cs_a_l = 1'b0;
        if (!last_round) begin
          addr_a = P_A + pidx_next;
        end else begin
          cs_b_l = 1'b0;
          addr_a = P_A + (dec_q ? addr_t'(0) : addr_t'(ROUNDS + 1));
          addr_b = P_A + (dec_q ? addr_t'(1) : addr_t'(ROUNDS));
        end
      end
`ifdef FEISTEL_WRITEBACK_EN
      WB: begin
        cs_a_l  = 1'b0;
        cs_b_l  = 1'b0;
        we_a_l  = 1'b0;
        we_b_l  = 1'b0;
        oe_a_l  = 1'b1;
        oe_b_l  = 1'b1;
        addr_a  = wb_addr_q;
        addr_b  = wb_addr_q + addr_t'(1);
        wdata_a = res_l_q;
        wdata_b = res_r_q;
      end
`endif
      default: ;
    endcase
  end

  assign ready   = (state_q == IDLE);
  assign busy    = ~ready;
  assign done    = (state_q == DONE);
  assign resultL = res_l_q;
  assign resultR = res_r_q;

endmodule

// File: tb/tb_feistel_engine.sv
// Directed bench for feistel_engine: a 16-round instance and a 2-round instance, each on its own SRAM model.
// Honours FEISTEL_WRITEBACK_EN for the write-back ports and the extra write-back cycle.
module tb_feistel_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int errors = 0;
  int checks = 0;

  // 16-round instance (default parameters)
  logic        start0, dec0;
  logic [31:0] l0, r0, rl0, rr0, da0, db0;
  logic        ready0, busy0, done0;
  logic [11:0] aa0, ab0;
  logic        csa0, csb0, wea0, web0, oea0, oeb0;
  // 2-round instance
  logic        start1, dec1;
  logic [31:0] l1, r1, rl1, rr1, da1, db1;
  logic        ready1, busy1, done1;
  logic [11:0] aa1, ab1;
  logic        csa1, csb1, wea1, web1, oea1, oeb1;
`ifdef FEISTEL_WRITEBACK_EN
  logic        wben0, wben1;
  logic [11:0] wbaddr0, wbaddr1;
  logic [31:0] wda0, wdb0, wda1, wdb1;
`endif

  logic [31:0] mem0 [0:4095];
  logic [31:0] mem1 [0:4095];

  feistel_engine u0 (
    .clk(clk), .reset(reset), .start(start0), .decrypt(dec0), .L(l0), .R(r0),
`ifdef FEISTEL_WRITEBACK_EN
    .wb_en(wben0), .wb_addr(wbaddr0), .wdata_a(wda0), .wdata_b(wdb0),
`endif
    .ready(ready0), .busy(busy0), .done(done0), .resultL(rl0), .resultR(rr0),
    .addr_a(aa0), .addr_b(ab0), .data_a(da0), .data_b(db0),
    .cs_a_l(csa0), .cs_b_l(csb0), .we_a_l(wea0), .we_b_l(web0), .oe_a_l(oea0), .oe_b_l(oeb0)
  );

  feistel_engine #(.ROUNDS(2), .ADDR_W(12), .S_BASE(0), .P_BASE(100)) u1 (
    .clk(clk), .reset(reset), .start(start1), .decrypt(dec1), .L(l1), .R(r1),
`ifdef FEISTEL_WRITEBACK_EN
    .wb_en(wben1), .wb_addr(wbaddr1), .wdata_a(wda1), .wdata_b(wdb1),
`endif
    .ready(ready1), .busy(busy1), .done(done1), .resultL(rl1), .resultR(rr1),
    .addr_a(aa1), .addr_b(ab1), .data_a(da1), .data_b(db1),
    .cs_a_l(csa1), .cs_b_l(csb1), .we_a_l(wea1), .we_b_l(web1), .oe_a_l(oea1), .oe_b_l(oeb1)
  );

  // Synchronous-read SRAMs: data appears the cycle after the selected address
  always @(posedge clk) begin
    if (!csa0 && wea0) da0 <= mem0[aa0];
    if (!csb0 && web0) db0 <= mem0[ab0];
    if (!csa1 && wea1) da1 <= mem1[aa1];
    if (!csb1 && web1) db1 <= mem1[ab1];
  end

  // Expected SRAM read trace of the 16-round instance, indexed by cycle
  logic        e_csa [0:63];
  logic        e_csb [0:63];
  logic [11:0] e_aa  [0:63];
  logic [11:0] e_ab  [0:63];

  function automatic logic [31:0] f_model(input logic [31:0] x);
    return ((mem0[x[31:24]] + mem0[256 + int'(x[23:16])]) ^ mem0[512 + int'(x[15:8])])
           + mem0[768 + int'(x[7:0])];
  endfunction

  // Reference Blowfish: xor P, F, swap per round; undo last swap; whiten
  function automatic logic [63:0] bf_model(input logic [31:0] l, input logic [31:0] r, input logic dec);
    logic [31:0] xl, xr, t;
    xl = l;
    xr = r;
    for (int i = 0; i < 16; i++) begin
      xl = xl ^ mem0[4000 + (dec ? 17 - i : i)];
      xr = xr ^ f_model(xl);
      t = xl; xl = xr; xr = t;
    end
    t = xl; xl = xr; xr = t;
    xr = xr ^ mem0[4000 + (dec ? 1 : 16)];
    xl = xl ^ mem0[4000 + (dec ? 0 : 17)];
    return {xl, xr};
  endfunction

  task automatic build_trace(input logic [31:0] l, input logic [31:0] r, input logic dec);
    logic [31:0] xl, xr, t;
    for (int k = 0; k < 64; k++) begin
      e_csa[k] = 1'b1; e_csb[k] = 1'b1; e_aa[k] = '0; e_ab[k] = '0;
    end
    xl = l;
    xr = r;
    e_csa[0] = 1'b0;
    e_aa[0]  = 12'(4000 + (dec ? 17 : 0));
    for (int i = 0; i < 16; i++) begin
      xl = xl ^ mem0[4000 + (dec ? 17 - i : i)];
      e_csa[3*i+1] = 1'b0; e_csb[3*i+1] = 1'b0;
      e_aa[3*i+1]  = 12'(int'(xl[31:24]));
      e_ab[3*i+1]  = 12'(256 + int'(xl[23:16]));
      e_csa[3*i+2] = 1'b0; e_csb[3*i+2] = 1'b0;
      e_aa[3*i+2]  = 12'(512 + int'(xl[15:8]));
      e_ab[3*i+2]  = 12'(768 + int'(xl[7:0]));
      e_csa[3*i+3] = 1'b0;
      if (i < 15) begin
        e_aa[3*i+3] = 12'(4000 + (dec ? 16 - i : i + 1));
      end else begin
        e_csb[3*i+3] = 1'b0;
        e_aa[3*i+3]  = 12'(4000 + (dec ? 0 : 17));
        e_ab[3*i+3]  = 12'(4000 + (dec ? 1 : 16));
      end
      t  = xr ^ f_model(xl);
      xr = xl;
      xl = t;
    end
  endtask

  // Start one block on the 16-round instance and wait (bounded) for done; cyc=-1 on timeout
  task automatic run0(input logic [31:0] l, input logic [31:0] r, input logic dec, output int cyc);
    @(negedge clk);
    l0 = l; r0 = r; dec0 = dec; start0 = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
    checks++; if ({rl0, rr0} !== 64'h0) begin errors++; $display("FAIL reset_results: got %h want 0", {rl0, rr0}); end
    checks++; if ({csa0, csb0} !== 2'b11) begin errors++; $display("FAIL reset_cs: got %b want 11", {csa0, csb0}); end
    checks++; if ({wea0, web0} !== 2'b11) begin errors++; $display("FAIL reset_we: got %b want 11", {wea0, web0}); end
    checks++; if ({oea0, oeb0} !== 2'b00) begin errors++; $display("FAIL reset_oe: got %b want 00", {oea0, oeb0}); end
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready_r2: got %b want 1", ready1); end
    reset = 1'b0;
  endtask

  task automatic test_zero_mem;
    int cyc;
    run0(32'h01234567, 32'h89ABCDEF, 1'b0, cyc);
    checks++; if (cyc !== 50) begin errors++; $display("FAIL zero_latency: got %0d want 50", cyc); end
    checks++; if (rl0 !== 32'h89ABCDEF) begin errors++; $display("FAIL zero_resultL: got %h want 89abcdef", rl0); end
    checks++; if (rr0 !== 32'h01234567) begin errors++; $display("FAIL zero_resultR: got %h want 01234567", rr0); end
  endtask

  task automatic test_p17;
    int cyc;
    mem0[4017] = 32'hFFFFFFFF;
    run0(32'h01234567, 32'h89ABCDEF, 1'b0, cyc);
    checks++; if (cyc !== 50) begin errors++; $display("FAIL p17_enc_latency: got %0d want 50", cyc); end
    checks++; if ({rl0, rr0} !== 64'h76543210_01234567) begin errors++; $display("FAIL p17_enc: got %h want 7654321001234567", {rl0, rr0}); end
    // Decrypt applies P[17] in the first round, so it lands on the left input half
    run0(32'h01234567, 32'h89ABCDEF, 1'b1, cyc);
    checks++; if (cyc !== 50) begin errors++; $display("FAIL p17_dec_latency: got %0d want 50", cyc); end
    checks++; if ({rl0, rr0} !== 64'h89ABCDEF_FEDCBA98) begin errors++; $display("FAIL p17_dec: got %h want 89abcdeffedcba98", {rl0, rr0}); end
    run0(32'h76543210, 32'h01234567, 1'b1, cyc);
    checks++; if ({rl0, rr0} !== 64'h01234567_89ABCDEF) begin errors++; $display("FAIL p17_roundtrip: got %h want 0123456789abcdef", {rl0, rr0}); end
  endtask

  task automatic test_start_while_busy;
    int dones, first;
    dones = 0;
    first = -1;
    @(negedge clk);
    l0 = 32'h01234567; r0 = 32'h89ABCDEF; dec0 = 1'b0; start0 = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start0 = (k == 5 || k == 20);
      l0 = 32'hCAFEF00D; r0 = 32'h5A5A5A5A; dec0 = 1'b1;
      if (done0) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    start0 = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", dones); end
    checks++; if (first !== 50) begin errors++; $display("FAIL busy_done_cycle: got %0d want 50", first); end
    checks++; if ({rl0, rr0} !== 64'h76543210_01234567) begin errors++; $display("FAIL busy_results: got %h want 7654321001234567", {rl0, rr0}); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL busy_ready_after: got %b want 1", ready0); end
  endtask

  task automatic test_reset_mid_block;
    int cyc;
    @(negedge clk);
    l0 = 32'h11112222; r0 = 32'h33334444; dec0 = 1'b0; start0 = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ready0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done0); end
    checks++; if ({rl0, rr0} !== 64'h0) begin errors++; $display("FAIL midrst_results: got %h want 0", {rl0, rr0}); end
    checks++; if ({csa0, csb0} !== 2'b11) begin errors++; $display("FAIL midrst_cs: got %b want 11", {csa0, csb0}); end
    run0(32'h01234567, 32'h89ABCDEF, 1'b0, cyc);
    checks++; if (cyc !== 50) begin errors++; $display("FAIL midrst_latency: got %0d want 50", cyc); end
    checks++; if ({rl0, rr0} !== 64'h76543210_01234567) begin errors++; $display("FAIL midrst_results_after: got %h want 7654321001234567", {rl0, rr0}); end
  endtask

  task automatic test_random_trace;
    logic [31:0] in_l, in_r;
    logic [63:0] exp_res;
    logic        dec;
    int          cyc;
    for (int i = 0; i < 1024; i++) mem0[i] = $urandom;
    for (int i = 4000; i < 4018; i++) mem0[i] = $urandom;
    in_l = 32'hDEADBEEF;
    in_r = 32'h00C0FFEE;
    for (int p = 0; p < 2; p++) begin
      dec = (p == 1);
      build_trace(in_l, in_r, dec);
      exp_res = bf_model(in_l, in_r, dec);
      @(negedge clk);
      l0 = in_l; r0 = in_r; dec0 = dec; start0 = 1'b1;
      cyc = -1;
      #1;
      for (int k = 0; k <= 60; k++) begin
        if (k > 0) begin
          @(negedge clk);
          start0 = 1'b0;
        end
        checks++; if (csa0 !== e_csa[k]) begin errors++; $display("FAIL trace_cs_a p%0d c%0d: got %b want %b", p, k, csa0, e_csa[k]); end
        if (!e_csa[k]) begin
          checks++; if (aa0 !== e_aa[k]) begin errors++; $display("FAIL trace_addr_a p%0d c%0d: got %0d want %0d", p, k, aa0, e_aa[k]); end
        end
        checks++; if (csb0 !== e_csb[k]) begin errors++; $display("FAIL trace_cs_b p%0d c%0d: got %b want %b", p, k, csb0, e_csb[k]); end
        if (!e_csb[k]) begin
          checks++; if (ab0 !== e_ab[k]) begin errors++; $display("FAIL trace_addr_b p%0d c%0d: got %0d want %0d", p, k, ab0, e_ab[k]); end
        end
        if (done0) begin
          cyc = k;
          break;
        end
      end
      checks++; if (cyc !== 50) begin errors++; $display("FAIL rand_latency p%0d: got %0d want 50", p, cyc); end
      checks++; if ({rl0, rr0} !== exp_res) begin errors++; $display("FAIL rand_model p%0d: got %h want %h", p, {rl0, rr0}, exp_res); end
      in_l = rl0;
      in_r = rr0;
    end
    checks++; if ({rl0, rr0} !== 64'hDEADBEEF_00C0FFEE) begin errors++; $display("FAIL rand_roundtrip: got %h want deadbeef00c0ffee", {rl0, rr0}); end
  endtask

  task automatic test_two_rounds;
    int cyc, want_cyc;
    bit wb_seen;
    mem1[103] = 32'h00000001;
    wb_seen = 1'b0;
`ifdef FEISTEL_WRITEBACK_EN
    want_cyc = 9;
`else
    want_cyc = 8;
`endif
    @(negedge clk);
    l1 = 32'hA5A5A5A5; r1 = 32'h12345678; dec1 = 1'b0; start1 = 1'b1;
`ifdef FEISTEL_WRITEBACK_EN
    wben1 = 1'b1; wbaddr1 = 12'd200;
`endif
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start1 = 1'b0;
`ifdef FEISTEL_WRITEBACK_EN
      if (!csa1 && !wea1) begin
        wb_seen = 1'b1;
        checks++; if ({aa1, ab1} !== {12'd200, 12'd201}) begin errors++; $display("FAIL wb_addr: got %0d/%0d want 200/201", aa1, ab1); end
        checks++; if ({wda1, wdb1} !== {32'h12345679, 32'hA5A5A5A5}) begin errors++; $display("FAIL wb_data: got %h want 12345679a5a5a5a5", {wda1, wdb1}); end
        checks++; if ({csb1, web1, oea1, oeb1} !== 4'b0011) begin errors++; $display("FAIL wb_ctrl: got %b want 0011", {csb1, web1, oea1, oeb1}); end
      end
`endif
      if (done1) begin
        cyc = k;
        break;
      end
    end
`ifdef FEISTEL_WRITEBACK_EN
    checks++; if (wb_seen !== 1'b1) begin errors++; $display("FAIL wb_seen: got %b want 1", wb_seen); end
`else
    checks++; if (wb_seen !== 1'b0) begin errors++; $display("FAIL wb_absent: got %b want 0", wb_seen); end
`endif
    checks++; if (cyc !== want_cyc) begin errors++; $display("FAIL r2_latency: got %0d want %0d", cyc, want_cyc); end
    checks++; if ({rl1, rr1} !== 64'h12345679_A5A5A5A5) begin errors++; $display("FAIL r2_results: got %h want 12345679a5a5a5a5", {rl1, rr1}); end
  endtask

  initial begin
    reset = 1'b1;
    start0 = 1'b0; dec0 = 1'b0; l0 = '0; r0 = '0;
    start1 = 1'b0; dec1 = 1'b0; l1 = '0; r1 = '0;
`ifdef FEISTEL_WRITEBACK_EN
    wben0 = 1'b0; wbaddr0 = '0; wben1 = 1'b0; wbaddr1 = '0;
`endif
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    test_reset;
    test_zero_mem;
    test_p17;
    test_start_while_busy;
    test_reset_mid_block;
    test_random_trace;
    test_two_rounds;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
